// File: rtl/prog_loader.sv
// prog_loader: receives a framed byte stream (A5, LEN lo, LEN hi, data words
// LSB first, 8-bit checksum), writes little-endian words into the program
// SRAM, and holds the core in reset until a verified image is in place.
module prog_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int unsigned MAX_WORDS = 4096,
    parameter int unsigned TIMEOUT   = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid_i,
    input  logic [7:0]  rx_data_i,
    output logic        rx_ready_o,
    output logic        mem_we_o,
    output logic [31:0] mem_waddr_o,
    output logic [31:0] mem_wdata_o,
    output logic        core_rst_o,
    output logic        done_o,
    output logic        err_o,
    output logic [1:0]  err_code_o
);

    localparam int          TW        = $clog2(TIMEOUT + 1);
    localparam logic [7:0]  SYNC_BYTE = 8'hA5;
    localparam logic [1:0]  ERR_TMO   = 2'b01;
    localparam logic [1:0]  ERR_LEN   = 2'b10;
    localparam logic [1:0]  ERR_CSUM  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERR
    } state_t;

    state_t         state_q, state_d;
    logic [7:0]     len_lo_q;
    logic [15:0]    len_q;
    logic [15:0]    word_cnt_q;
    logic [1:0]     byte_idx_q;
    logic [23:0]    word_buf_q;
    logic [7:0]     sum_q;
    logic [TW-1:0]  tmo_cnt_q;

    logic           accept;
    logic           active;
    logic           tmo_hit;
    logic [15:0]    len_full;
    logic           too_long;
    logic           last_word;
    logic           start;
    logic           err_set;
    logic [1:0]     err_code_set;
    logic           done_set;
    logic           take;

    assign accept    = rx_valid_i & rx_ready_o;
    assign active    = (state_q == S_LEN0) || (state_q == S_LEN1) ||
                       (state_q == S_DATA) || (state_q == S_CSUM);
    assign tmo_hit   = active && (tmo_cnt_q == TW'(TIMEOUT - 1));
    assign take      = accept && !tmo_hit;
    assign len_full  = {rx_data_i, len_lo_q};
    assign too_long  = {16'd0, len_full} > MAX_WORDS;
    assign last_word = (word_cnt_q == len_q - 16'd1);

    // Next-state decode plus one-cycle control strobes for the datapath.
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latches).
        state_d      = state_q;
        start        = 1'b0;
        err_set      = 1'b0;
        err_code_set = 2'b00;
        done_set     = 1'b0;
        if (accept) begin
            case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    if (rx_data_i == SYNC_BYTE) begin
                        state_d = S_LEN0;
                        start   = 1'b1;
                    end
                end
                S_LEN0: state_d = S_LEN1;
                S_LEN1: begin
                    if (too_long) begin
                        state_d      = S_ERR;
                        err_set      = 1'b1;
                        err_code_set = ERR_LEN;
                    end else if (len_full == 16'd0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA;
                    end
                end
                S_DATA: begin
                    if (byte_idx_q == 2'd3 && last_word) state_d = S_CSUM;
                end
                S_CSUM: begin
                    if (rx_data_i == sum_q) begin
                        state_d  = S_DONE;
                        done_set = 1'b1;
                    end else begin
                        state_d      = S_ERR;
                        err_set      = 1'b1;
                        err_code_set = ERR_CSUM;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        // An expiring timeout overrides whatever byte arrives in that cycle.
        if (tmo_hit) begin
            state_d      = S_ERR;
            err_set      = 1'b1;
            err_code_set = ERR_TMO;
            done_set     = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Datapath: word assembly, checksum, address, timeout and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_ready_o  <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_waddr_o <= BASE_ADDR;
            mem_wdata_o <= 32'h0;
            core_rst_o  <= 1'b1;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            err_code_o  <= 2'b00;
            len_lo_q    <= 8'h0;
            len_q       <= 16'h0;
            word_cnt_q  <= 16'h0;
            byte_idx_q  <= 2'd0;
            word_buf_q  <= 24'h0;
            sum_q       <= 8'h0;
            tmo_cnt_q   <= '0;
        end else begin
            rx_ready_o <= 1'b1;
            mem_we_o   <= 1'b0;

            // Address advances in the cycle after the write it belonged to.
            if (mem_we_o) mem_waddr_o <= mem_waddr_o + 32'd4;

            if (!active || accept || tmo_hit) tmo_cnt_q <= '0;
            else                              tmo_cnt_q <= tmo_cnt_q + 1'b1;

            if (start) begin
                done_o      <= 1'b0;
                err_o       <= 1'b0;
                err_code_o  <= 2'b00;
                core_rst_o  <= 1'b1;
                sum_q       <= 8'h0;
                mem_waddr_o <= BASE_ADDR;
                byte_idx_q  <= 2'd0;
                word_cnt_q  <= 16'h0;
            end

            if (take && state_q == S_LEN0) len_lo_q <= rx_data_i;
            if (take && state_q == S_LEN1) len_q    <= len_full;

            if (take && state_q == S_DATA) begin
                sum_q      <= sum_q + rx_data_i;
                byte_idx_q <= byte_idx_q + 2'd1;
                case (byte_idx_q)
                    2'd0: word_buf_q[7:0]   <= rx_data_i;
                    2'd1: word_buf_q[15:8]  <= rx_data_i;
                    2'd2: word_buf_q[23:16] <= rx_data_i;
                    default: begin
                        mem_we_o    <= 1'b1;
                        mem_wdata_o <= {rx_data_i, word_buf_q};
                        word_cnt_q  <= word_cnt_q + 16'd1;
                    end
                endcase
            end

            if (err_set) begin
                err_o      <= 1'b1;
                err_code_o <= err_code_set;
                core_rst_o <= 1'b1;
            end
            if (done_set) begin
                done_o     <= 1'b1;
                core_rst_o <= 1'b0;
            end
        end
    end

endmodule
